// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive path: digit patterns
// (bit 0 = a ... bit 6 = g), the blank pattern and the reader FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Successor digit in a modulo-10 count, so 9 is followed by 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> {legal, digit}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segments,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (segments)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples an asynchronous segment bus, waits for each pattern to settle, decodes
// it to a BCD digit and reports inter-digit period and sequence/pattern errors.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          segments_in,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                seg_invalid,
  output logic                seq_error,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == {PERIOD_W{1'b1}}) ? v : v + PERIOD_W'(1);
  endfunction

  logic [6:0]          sync_p0;
  logic [6:0]          sync_p1;
  logic [3:0]          stable_cnt;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_inc;
  state_t              state;
  state_t              state_next;
  logic                match;
  logic                settle;
  logic                legal;
  logic [3:0]          dec_digit;
  logic                accept;
  logic                latch_period;
  logic                invalid_next;
  logic                seq_next;

  // Stage p0/p1: two-flop synchroniser for the asynchronous segment bus
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= segments_in;
      sync_p1 <= sync_p0;
    end
  end

  // The sample about to enter sync_p1 is compared with the one already held,
  // so the settle decision lands on the same edge the run completes.
  assign match  = (sync_p0 == sync_p1);
  assign settle = match && (stable_cnt == STABLE_MAX - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
    end else if (!match) begin
      stable_cnt <= '0;
    end else if (stable_cnt != STABLE_MAX) begin
      stable_cnt <= stable_cnt + 4'd1;
    end
  end

  seg7_decode u_decode (
    .segments (sync_p1),
    .legal    (legal),
    .digit    (dec_digit)
  );

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    latch_period = 1'b0;
    invalid_next = 1'b0;
    seq_next     = 1'b0;
    if (settle && (sync_p1 != SEG_BLANK)) begin
      if (!legal) begin
        invalid_next = 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            accept     = 1'b1;
            state_next = LOCKED;
          end
          LOCKED: begin
            if (dec_digit != digit_out) begin
              accept       = 1'b1;
              latch_period = 1'b1;
              seq_next     = (dec_digit != next_digit(digit_out));
            end
          end
          default: state_next = EMPTY;
        endcase
      end
    end
  end

  // Latched period is the edge count up to and including the accepting edge.
  assign period_inc = sat_inc(period_cnt);

  // Stage p2: FSM state, registered event pulses and period bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      digit_out    <= '0;
      digit_valid  <= 1'b0;
      seg_invalid  <= 1'b0;
      seq_error    <= 1'b0;
      period_cnt   <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      state       <= state_next;
      digit_valid <= accept;
      seg_invalid <= invalid_next;
      seq_error   <= seq_next;
      period_cnt  <= accept ? '0 : period_inc;
      if (accept) begin
        digit_out <= dec_digit;
      end
      if (latch_period) begin
        period_out   <= period_inc;
        period_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised and directed bench for seg7_reader against an edge-history reference model.
module tb_seg7_reader;

  localparam int S      = 4;
  localparam int HIST_N = 20;
  localparam logic [6:0] PATS [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111
  };

  logic        clk;
  logic        rst;
  logic [6:0]  segs;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic        seg_invalid;
  logic        seq_error;
  logic [23:0] period_out;
  logic        period_valid;
  logic [3:0]  digit_out8;
  logic        digit_valid8;
  logic        seg_invalid8;
  logic        seq_error8;
  logic [7:0]  period_out8;
  logic        period_valid8;

  int checks   = 0;
  int failures = 0;

  seg7_reader #(.STABLE_CYCLES(S), .PERIOD_W(24)) dut (
    .clk(clk), .reset(rst), .segments_in(segs),
    .digit_out(digit_out), .digit_valid(digit_valid), .seg_invalid(seg_invalid),
    .seq_error(seq_error), .period_out(period_out), .period_valid(period_valid)
  );

  seg7_reader #(.STABLE_CYCLES(S), .PERIOD_W(8)) dut8 (
    .clk(clk), .reset(rst), .segments_in(segs),
    .digit_out(digit_out8), .digit_valid(digit_valid8), .seg_invalid(seg_invalid8),
    .seq_error(seq_error8), .period_out(period_out8), .period_valid(period_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: input value seen at each edge, newest first.
  logic [6:0] hist [HIST_N];
  bit         m_locked;
  int         m_digit;
  bit         m_dv, m_inv, m_seq, m_pvalid;
  int         m_since;
  int         m_period;

  function automatic int decode_ref(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (PATS[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [6:0] pat, input bit r);
    logic [6:0] p;
    bit         ev;
    int         d;
    if (r) begin
      for (int i = 0; i < HIST_N; i++) hist[i] = 7'd0;
      m_locked = 0; m_digit = 0; m_dv = 0; m_inv = 0; m_seq = 0;
      m_pvalid = 0; m_since = 0; m_period = 0;
      return;
    end
    for (int i = HIST_N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pat;
    m_dv = 0; m_inv = 0; m_seq = 0;
    m_since++;
    // A pattern settles on the edge after it has been present on S+1 edges in a row.
    p  = hist[1];
    ev = (hist[S+2] != p);
    for (int i = 1; i <= S + 1; i++) if (hist[i] != p) ev = 0;
    if (ev && p != 7'd0) begin
      d = decode_ref(p);
      if (d < 0) begin
        m_inv = 1;
      end else if (!m_locked || d != m_digit) begin
        if (m_locked) begin
          m_seq    = (d != (m_digit + 1) % 10);
          m_period = m_since;
          m_pvalid = 1;
        end
        m_locked = 1;
        m_digit  = d;
        m_dv     = 1;
        m_since  = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("digit_out",     {28'd0, digit_out},   m_digit);
    chk("digit_valid",   {31'd0, digit_valid}, {31'd0, m_dv});
    chk("seg_invalid",   {31'd0, seg_invalid}, {31'd0, m_inv});
    chk("seq_error",     {31'd0, seq_error},   {31'd0, m_seq});
    chk("period_out",    {8'd0, period_out},   (m_period > 24'hFFFFFF) ? 32'hFFFFFF : m_period);
    chk("period_valid",  {31'd0, period_valid}, {31'd0, m_pvalid});
    chk("period_out8",   {24'd0, period_out8}, (m_period > 255) ? 32'd255 : m_period);
    chk("period_valid8", {31'd0, period_valid8}, {31'd0, m_pvalid});
  endtask

  task automatic step(input logic [6:0] pat, input bit r);
    segs = pat;
    rst  = r;
    @(posedge clk);
    model_edge(pat, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    repeat (n) step(pat, 1'b0);
  endtask

  initial begin
    int         sel;
    logic [6:0] pat;
    int         dv_seen;
    int         inv_seen;
    rst  = 1'b1;
    segs = 7'd0;
    @(negedge clk);
    step(7'd0, 1'b1);
    step(7'd0, 1'b1);

    // Settle latency and first-digit behaviour
    dv_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step(PATS[0], 1'b0);
      if (digit_valid) dv_seen = i;
    end
    chk("latency_edges", dv_seen, S + 2);

    // Period and 9 -> 0 wrap
    hold(PATS[8], 1000);
    hold(PATS[9], 1000);
    hold(PATS[0], 1000);
    chk("period_1000", {8'd0, period_out}, 32'd1000);

    // Out-of-sequence digit
    hold(PATS[3], 20);
    hold(PATS[5], 20);
    chk("seq_digit", {28'd0, digit_out}, 32'd5);

    // Glitch rejection
    hold(PATS[2], 20);
    hold(7'b1111111, 3);
    hold(PATS[2], 20);
    chk("glitch_digit", {28'd0, digit_out}, 32'd2);

    // Illegal and blank patterns
    inv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'b1010101, 1'b0);
      inv_seen += int'(seg_invalid);
    end
    step(7'b0000000, 1'b0);
    inv_seen += int'(seg_invalid);
    chk("illegal_once", inv_seen, 32'd1);
    hold(7'b0000000, 20);

    // Period counter saturation on the narrow instance
    hold(PATS[1], 300);
    hold(PATS[2], 300);
    chk("period_sat8", {24'd0, period_out8}, 32'd255);

    // Reset mid-settle, then a fresh first digit
    hold(PATS[3], 3);
    step(PATS[3], 1'b1);
    chk("rst_digit", {28'd0, digit_out}, 32'd0);
    chk("rst_pvalid", {31'd0, period_valid}, 32'd0);
    hold(PATS[7], 20);

    // Randomised pattern stream
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      pat = PATS[(m_digit + 1) % 10];
      else if (sel <= 7) pat = PATS[$urandom_range(0, 9)];
      else if (sel == 8) pat = 7'($urandom_range(0, 127));
      else               pat = 7'd0;
      if ($urandom_range(0, 39) == 0) step(pat, 1'b1);
      hold(pat, $urandom_range(1, 12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
